// File: rtl/alu_shift_seq.sv
// Multi-cycle 16-bit shift/rotate unit: one bit position per clock, start/busy/done handshake,
// registered result with carry-out and zero flags.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; result/carry/zero hold last completed op
// ST_SHIFT | one shift/rotate step per edge until the amount is used up
// ST_DONE  | single-cycle done pulse, busy still high, back to idle next
module alu_shift_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [CNT_W-1:0] amt,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SAR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] work_q,   work_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       opr_q,    opr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;
    logic             zero_q,   zero_d;

    logic [WIDTH-1:0] step_w;
    logic             step_out;

    // Single-position step of the latched operation; no-op codes leave work untouched.
    always_comb begin
        step_w   = work_q;
        step_out = 1'b0;
        case (opr_q)
            OP_SHL: begin
                step_w   = {work_q[WIDTH-2:0], 1'b0};
                step_out = work_q[WIDTH-1];
            end
            OP_SHR: begin
                step_w   = {1'b0, work_q[WIDTH-1:1]};
                step_out = work_q[0];
            end
            OP_SAR: begin
                step_w   = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                step_out = work_q[0];
            end
            OP_ROL: begin
                step_w   = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
                step_out = work_q[WIDTH-1];
            end
            OP_ROR: begin
                step_w   = {work_q[0], work_q[WIDTH-1:1]};
                step_out = work_q[0];
            end
            default: begin
                step_w   = work_q;
                step_out = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        opr_d    = opr_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d = a;
                    cnt_d  = amt;
                    opr_d  = op;
                    if (amt == '0) begin
                        // Zero amount skips SHIFT, so the outputs are loaded straight from the operand.
                        state_d  = ST_DONE;
                        result_d = a;
                        carry_d  = 1'b0;
                        zero_d   = (a == '0);
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_w;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_DONE;
                    result_d = step_w;
                    carry_d  = step_out;
                    zero_d   = (step_w == '0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            opr_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            opr_q    <= opr_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: arithmetic reference model checked every cycle, directed literal
// cases for the documented scenarios, then randomized traffic.
module tb_alu_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [3:0]  amt;
    logic [2:0]  op;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    alu_shift_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .amt    (amt),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Whole-operation result computed with plain shifts on a wide integer.
    task automatic model_op(input logic [15:0] ia, input int n, input logic [2:0] iop,
                            output logic [15:0] r, output logic c);
        logic [31:0] x;
        logic [31:0] t;
        logic signed [31:0] s;
        x = {16'h0, ia};
        s = {{16{ia[15]}}, ia};
        t = x;
        c = 1'b0;
        case (iop)
            3'd0: begin t = x << n;  if (n > 0) c = x[16-n]; end
            3'd1: begin t = x >> n;  if (n > 0) c = x[n-1];  end
            3'd2: begin t = s >>> n; if (n > 0) c = x[n-1];  end
            3'd3: begin t = (x << n) | (x >> (16 - n)); if (n > 0) c = t[0];  end
            3'd4: begin t = (x >> n) | (x << (16 - n)); if (n > 0) c = t[15]; end
            default: begin t = x; c = 1'b0; end
        endcase
        r = t[15:0];
    endtask

    // Timing model: an op accepted at edge number acc completes at edge acc+amt,
    // done shows in the cycle after that edge, and idle returns one edge later.
    int          cyc = 0;
    int          done_edge = 0;
    bit          m_active = 0;
    logic [15:0] pend_res, pub_res = '0;
    logic        pend_c, pub_c = 1'b0, pub_z = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0;
            pub_res  = '0;
            pub_c    = 1'b0;
            pub_z    = 1'b0;
        end else begin
            cyc++;
            if (m_active) begin
                if (cyc == done_edge + 1) m_active = 0;
            end else if (start) begin
                m_active  = 1;
                done_edge = cyc + int'(amt);
                model_op(a, int'(amt), op, pend_res, pend_c);
            end
            if (m_active && cyc == done_edge) begin
                pub_res = pend_res;
                pub_c   = pend_c;
                pub_z   = (pend_res == 16'h0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_busy",   32'(busy),   32'(m_active));
            chk("m_done",   32'(done),   32'(m_active && cyc == done_edge));
            chk("m_result", 32'(result), 32'(pub_res));
            chk("m_carry",  32'(carry),  32'(pub_c));
            chk("m_zero",   32'(zero),   32'(pub_z));
        end
    end

    task automatic run_op(input string nm, input logic [15:0] ia, input logic [3:0] iamt,
                          input logic [2:0] iop, input logic [15:0] er, input logic ec,
                          input logic ez);
        bit got;
        got = 0;
        @(negedge clk);
        a = ia; amt = iamt; op = iop; start = 1'b1;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 1) chk({nm, "_busy"}, 32'(busy), 32'd1);
            if (done) begin
                got = 1;
                chk({nm, "_lat"},    32'(i),      32'(iamt) + 32'd1);
                chk({nm, "_result"}, 32'(result), 32'(er));
                chk({nm, "_carry"},  32'(carry),  32'(ec));
                chk({nm, "_zero"},   32'(zero),   32'(ez));
            end
        end
        if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({nm, "_done_low"}, 32'(done), 32'd0);
    endtask

    task automatic wait_done(input string nm);
        bit got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; amt = '0; op = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry",  32'(carry),  32'd0);
        chk("rst_zero",   32'(zero),   32'd0);
        rst_n = 1'b1;

        run_op("shl4",   16'h0001, 4'd4,  3'b000, 16'h0010, 1'b0, 1'b0);
        run_op("shr2",   16'h0003, 4'd2,  3'b001, 16'h0000, 1'b1, 1'b1);
        run_op("sar15",  16'h8000, 4'd15, 3'b010, 16'hFFFF, 1'b0, 1'b0);
        run_op("rol1",   16'h8001, 4'd1,  3'b011, 16'h0003, 1'b1, 1'b0);
        run_op("ror4",   16'h0001, 4'd4,  3'b100, 16'h1000, 1'b0, 1'b0);
        run_op("nop110", 16'hBEEF, 4'd3,  3'b110, 16'hBEEF, 1'b0, 1'b0);
        run_op("shl0",   16'h1234, 4'd0,  3'b000, 16'h1234, 1'b0, 1'b0);

        // start pulsed while busy must be dropped
        @(negedge clk);
        a = 16'h0001; amt = 4'd8; op = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busyblk");
        chk("busyblk_result", 32'(result), 32'h0100);
        chk("busyblk_carry",  32'(carry),  32'd0);

        // start raised in the DONE cycle is accepted only one cycle later
        @(negedge clk);
        a = 16'h0005; amt = 4'd2; op = 3'b000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("donecyc_first");
        a = 16'h1234; amt = 4'd0; op = 3'b000; start = 1'b1;
        @(negedge clk);
        chk("donecyc_ignored_busy", 32'(busy), 32'd0);
        chk("donecyc_ignored_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("donecyc_accept_done",   32'(done),   32'd1);
        chk("donecyc_accept_result", 32'(result), 32'h1234);
        @(negedge clk);

        // asynchronous reset in the middle of a rotate
        a = 16'h00FF; amt = 4'd10; op = 3'b011; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy",   32'(busy),   32'd0);
        chk("arst_done",   32'(done),   32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_carry",  32'(carry),  32'd0);
        chk("arst_zero",   32'(zero),   32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_hold_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("arst_no_done", 32'(done), 32'd0);
        end
        run_op("post_rst_shr8", 16'h0100, 4'd8, 3'b001, 16'h0001, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a     = 16'($urandom);
            amt   = 4'($urandom_range(0, 15));
            op    = 3'($urandom_range(0, 7));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
